// File: rtl/debug_mode_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_mode_controller_if
// Brief    : Front-panel button inputs and debug-control outputs bundle.
// Revision : 1.0
// ============================================================================
interface debug_mode_controller_if;
    logic       i_Mode_BTN;
    logic       i_Step_BTN;
    logic       o_Debug_CLK_EN;
    logic       o_Step_Pulse;
    logic [1:0] o_State;

    modport master (
        output i_Mode_BTN,
        output i_Step_BTN,
        input  o_Debug_CLK_EN,
        input  o_Step_Pulse,
        input  o_State
    );

    modport slave (
        input  i_Mode_BTN,
        input  i_Step_BTN,
        output o_Debug_CLK_EN,
        output o_Step_Pulse,
        output o_State
    );
endinterface
`default_nettype wire

// File: rtl/debug_mode_controller.sv
`default_nettype none
// ============================================================================
// Module   : debug_mode_controller
// Brief    : Synchronises/debounces MODE and STEP buttons and runs the
//            NORMAL/DEBUG/STEP control FSM for the debug clock divider.
// Revision : 1.0
// ============================================================================
module debug_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    debug_mode_controller_if.slave bus
);

    localparam int               c_NUM_BTN = 2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_DEBUG  = 2'b01,
        ST_STEP   = 2'b10
    } state_t;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_press;
    logic                 w_mode_press;
    logic                 w_step_press;

    // Bit 0 = MODE, bit 1 = STEP
    assign w_raw        = {bus.i_Step_BTN, bus.i_Mode_BTN};
    assign w_mode_press = w_press[0];
    assign w_step_press = w_press[1];

    for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             deb_q;
        logic             deb_d;
        logic             deb_prev_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // The level must differ for DEBOUNCE_CYCLES consecutive cycles to be taken.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync2_q != deb_q) begin
                if (cnt_q == c_CNT_MAX) begin
                    deb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge i_CLK or posedge i_RST) begin
            if (i_RST) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= w_raw[g];
                sync2_q    <= sync1_q;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                cnt_q      <= cnt_d;
            end
        end

        assign w_press[g] = deb_q & ~deb_prev_q;
    end

    state_t state_q;
    state_t state_d;
    logic   pend_q;
    logic   pend_d;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_NORMAL;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // A MODE press seen during STEP is parked in pend and honoured from DEBUG.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_NORMAL: begin
                pend_d = 1'b0;
                if (w_mode_press) begin
                    state_d = ST_DEBUG;
                end
            end
            ST_DEBUG: begin
                if (w_mode_press || pend_q) begin
                    state_d = ST_NORMAL;
                    pend_d  = 1'b0;
                end else if (w_step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_DEBUG;
                if (w_mode_press) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_State        = state_q;
    assign bus.o_Debug_CLK_EN = (state_q == ST_DEBUG) || (state_q == ST_STEP);
    assign bus.o_Step_Pulse   = (state_q == ST_STEP);

endmodule
`default_nettype wire

// File: tb/tb_debug_mode_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_mode_controller
// Brief    : Directed self-checking bench for debug_mode_controller.
// Revision : 1.0
// ============================================================================
module tb_debug_mode_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int   pulse_hi;
    int   pulse_rise;
    logic prev_pulse;
    logic saw_step;
    logic saw_en0;
    logic saw_en1;
    logic saw_change;
    logic [1:0] start_state;
    int   n;

    debug_mode_controller_if bus ();

    debug_mode_controller #(
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulse_hi    = 0;
        pulse_rise  = 0;
        prev_pulse  = bus.o_Step_Pulse;
        saw_step    = 1'b0;
        saw_en0     = 1'b0;
        saw_en1     = 1'b0;
        saw_change  = 1'b0;
        start_state = bus.o_State;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.o_Step_Pulse === 1'b1) pulse_hi++;
            if (bus.o_Step_Pulse === 1'b1 && prev_pulse !== 1'b1) pulse_rise++;
            prev_pulse = bus.o_Step_Pulse;
            if (bus.o_State === 2'b10) saw_step = 1'b1;
            if (bus.o_Debug_CLK_EN !== 1'b1) saw_en0 = 1'b1;
            if (bus.o_Debug_CLK_EN === 1'b1) saw_en1 = 1'b1;
            if (bus.o_State !== start_state) saw_change = 1'b1;
        end
    endtask

    task automatic enter_debug(input string tag);
        bus.i_Mode_BTN = 1'b1;
        run(20);
        bus.i_Mode_BTN = 1'b0;
        run(10);
        chk(tag, 32'(bus.o_State), 32'd1);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.i_Mode_BTN = 1'b0;
        bus.i_Step_BTN = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_en",    32'(bus.o_Debug_CLK_EN), 32'd0);
        chk("reset_pulse", 32'(bus.o_Step_Pulse),   32'd0);
        chk("reset_state", 32'(bus.o_State),        32'd0);
        rst = 1'b0;
        run(3);

        // 1: MODE press enters DEBUG after 2 sync + 4 debounce + 1 FSM edges
        bus.i_Mode_BTN = 1'b1;
        n = 0;
        while (n < 20 && bus.o_Debug_CLK_EN !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency_in_6_to_8", 32'(n >= 6 && n <= 8), 32'd1);
        chk("t1_state", 32'(bus.o_State), 32'd1);
        clear_mon();
        run(20 - n);
        bus.i_Mode_BTN = 1'b0;
        run(10);
        chk("t1_release_ignored", 32'(saw_change), 32'd0);
        chk("t1_en_hold", 32'(bus.o_Debug_CLK_EN), 32'd1);

        // 2: held STEP gives one single-cycle pulse
        clear_mon();
        bus.i_Step_BTN = 1'b1;
        run(20);
        bus.i_Step_BTN = 1'b0;
        run(10);
        chk("t2_pulse_count", 32'(pulse_rise), 32'd1);
        chk("t2_pulse_width", 32'(pulse_hi),   32'd1);
        chk("t2_saw_step",    32'(saw_step),   32'd1);
        chk("t2_en_drop",     32'(saw_en0),    32'd0);
        chk("t2_state",       32'(bus.o_State), 32'd1);

        // 7: MODE press landing in STEP is held and applied from DEBUG
        clear_mon();
        bus.i_Step_BTN = 1'b1;
        @(negedge clk);
        bus.i_Mode_BTN = 1'b1;
        run(20);
        bus.i_Step_BTN = 1'b0;
        bus.i_Mode_BTN = 1'b0;
        run(10);
        chk("t7_pulse_count", 32'(pulse_rise),  32'd1);
        chk("t7_state",       32'(bus.o_State), 32'd0);
        chk("t7_en",          32'(bus.o_Debug_CLK_EN), 32'd0);

        // 3: short bounce never accepted
        clear_mon();
        bus.i_Mode_BTN = 1'b1; run(1);
        bus.i_Mode_BTN = 1'b0; run(1);
        bus.i_Mode_BTN = 1'b1; run(1);
        bus.i_Mode_BTN = 1'b0; run(15);
        chk("t3_state_change", 32'(saw_change), 32'd0);
        chk("t3_en_seen",      32'(saw_en1),    32'd0);

        // 4: STEP ignored in NORMAL
        clear_mon();
        bus.i_Step_BTN = 1'b1;
        run(20);
        bus.i_Step_BTN = 1'b0;
        run(10);
        chk("t4_pulse",        32'(pulse_hi),   32'd0);
        chk("t4_state_change", 32'(saw_change), 32'd0);

        // 5: simultaneous MODE and STEP in DEBUG, MODE wins
        enter_debug("t5_enter_debug");
        clear_mon();
        bus.i_Mode_BTN = 1'b1;
        bus.i_Step_BTN = 1'b1;
        run(20);
        bus.i_Mode_BTN = 1'b0;
        bus.i_Step_BTN = 1'b0;
        run(10);
        chk("t5_pulse",    32'(pulse_hi),    32'd0);
        chk("t5_saw_step", 32'(saw_step),    32'd0);
        chk("t5_state",    32'(bus.o_State), 32'd0);

        // 6: reset in the middle of a STEP debounce count
        enter_debug("t6_enter_debug");
        bus.i_Step_BTN = 1'b1;
        run(4);
        rst = 1'b1;
        #1;
        chk("t6_rst_en",    32'(bus.o_Debug_CLK_EN), 32'd0);
        chk("t6_rst_state", 32'(bus.o_State),        32'd0);
        chk("t6_rst_pulse", 32'(bus.o_Step_Pulse),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        run(20);
        bus.i_Step_BTN = 1'b0;
        run(10);
        chk("t6_pulse_after", 32'(pulse_hi),    32'd0);
        chk("t6_state_after", 32'(bus.o_State), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
